uart_core: RTL and testbench

Parametrised full-duplex UART for the serial echo design, replacing the separate divider/receiver/transmitter trio with one block. It has an internal baud generator, an oversampled receiver with start-bit validation, and a transmitter. Frame format is configurable: data width, parity and stop bits. Both directions use valid/ready handshakes and report frame, parity and overrun errors. It sits between the board UART pins and the control logic.

---
 rtl/uart_core.sv | 205 ++++++++++++++++++++
 tb/tb_uart_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// Full-duplex UART: tick-driven oversampled RX with start validation, BP-counted TX, configurable frame.
// TX line changes one cycle after acceptance; RX flags a word ~mid-stop + 3; tx_ready only in IDLE; a word not yet taken is overwritten and flagged as overrun.
module uart_core #(
  parameter int CLK_DIV    = 326,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RXD,
  output logic                 UART_TXD,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int BP = CLK_DIV * OVERSAMPLE;
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(BP);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [TW-1:0]          rx_tcnt_q, rx_tcnt_d;
  logic [3:0]             rx_bcnt_q, rx_bcnt_d, tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d;
  logic                   rx_par_q, rx_par_d, rx_valid_q, rx_valid_d;
  logic                   ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic [BW-1:0]          tx_cnt_q, tx_cnt_d;
  logic                   tx_par_q, tx_par_d, txd_q, txd_d;
  logic                   tick, rx_bit_end, tx_bit_end;

  assign tick       = (div_q == DW'(CLK_DIV - 1));
  assign div_d      = tick ? '0 : div_q + 1'b1;
  assign rx_bit_end = tick && (rx_tcnt_q == TW'(OVERSAMPLE - 1));
  assign tx_bit_end = (tx_cnt_q == BW'(BP - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = ovr_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (tick && rx_state_q != S_IDLE) rx_tcnt_d = rx_tcnt_q + 1'b1;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = S_START;
          rx_tcnt_d  = '0;
        end
      end
      S_START: begin
        // Mid-start resample: a line back high here was a glitch.
        if (tick && rx_tcnt_q == TW'(OVERSAMPLE / 2 - 1)) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rxd_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_tcnt_d = '0;
          rx_sh_d   = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bcnt_q == 4'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else                                rx_bcnt_d  = rx_bcnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (rx_bit_end) begin
          rx_tcnt_d  = '0;
          rx_par_d   = rxd_s2_q;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_state_d = S_IDLE;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          ferr_d     = !rxd_s2_q;
          perr_d     = (PARITY != 0) && ((^rx_sh_q ^ rx_par_q) != (PARITY == 1));
          if (rx_valid_q && !rx_ready) ovr_d = 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_bcnt_d  = tx_bcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_sh_d    = tx_data;
          tx_par_d   = (^tx_data) ^ (PARITY == 1);
        end
      end
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA;
        tx_bcnt_d  = '0;
      end
      S_DATA: if (tx_bit_end) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bcnt_q == 4'(DATA_BITS - 1)) begin
          tx_bcnt_d  = '0;
          tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          tx_bcnt_d = tx_bcnt_q + 1'b1;
        end
      end
      S_PAR: if (tx_bit_end) begin
        tx_state_d = S_STOP;
        tx_bcnt_d  = '0;
      end
      S_STOP: if (tx_bit_end) begin
        if (tx_bcnt_q == 4'(STOP_BITS - 1)) tx_state_d = S_IDLE;
        else                               tx_bcnt_d  = tx_bcnt_q + 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      S_PAR:   txd_d = tx_par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bcnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      div_q      <= div_d;
      rxd_s1_q   <= UART_RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign UART_TXD      = txd_q;
  assign tx_ready      = (tx_state_q == S_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: an 8N1 and an 8E1 instance, BP = 64 cycles; received words are checked against a scoreboard.
module tb_uart_core;
  localparam int CD = 4;
  localparam int OS = 16;
  localparam int BP = CD * OS;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       bad_par;
    logic       stop_low;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk, reset;
  logic       loop_en, rxd_drv_n, rxd_drv_e, tx_sel, tx_vld;
  logic [7:0] tx_dat;
  logic       rx_ready_n, rx_ready_e;
  logic       rxd_n, txd_n, txd_e, tx_ready_n, tx_ready_e, tx_valid_n, tx_valid_e;
  logic [7:0] rx_data_n, rx_data_e;
  logic       rx_valid_n, rx_valid_e, ferr_n, ferr_e, perr_n, perr_e, ovr_n, ovr_e;
  logic       mon_txd, mon_rdy;

  int   n_chk = 0;
  int   n_pass = 0;
  int   rx_seen_n = 0;
  exp_t sb_q[$];
  exp_t me_n, me_e;
  vec_t vecs[6];

  assign rxd_n      = loop_en ? txd_n : rxd_drv_n;
  assign tx_valid_n = tx_vld & ~tx_sel;
  assign tx_valid_e = tx_vld & tx_sel;
  assign mon_txd    = tx_sel ? txd_e : txd_n;
  assign mon_rdy    = tx_sel ? tx_ready_e : tx_ready_n;

  uart_core #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset(reset), .UART_RXD(rxd_n), .UART_TXD(txd_n),
    .tx_data(tx_dat), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .rx_frame_err(ferr_n), .rx_parity_err(perr_n), .rx_overrun(ovr_n));

  uart_core #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset(reset), .UART_RXD(rxd_drv_e), .UART_TXD(txd_e),
    .tx_data(tx_dat), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .rx_frame_err(ferr_e), .rx_parity_err(perr_e), .rx_overrun(ovr_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic build(input logic [7:0] d, input logic par_en, input logic bad_par,
                       input logic stop_low, output logic [10:0] bits, output int n);
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (par_en) begin
      bits[9] = (^d) ^ bad_par;
      n = 10;
    end
    bits[n] = ~stop_low;
    n++;
  endtask

  always @(negedge clk) begin
    if (rx_valid_n && rx_ready_n) begin
      rx_seen_n++;
      if (sb_q.size() == 0) chk("rx_n_unexpected_word", 1, 0);
      else begin
        me_n = sb_q.pop_front();
        chk("rx_n_data", int'(rx_data_n), int'(me_n.data));
        chk("rx_n_parity_err", int'(perr_n), int'(me_n.perr));
        chk("rx_n_frame_err", int'(ferr_n), int'(me_n.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid_e && rx_ready_e) begin
      if (sb_q.size() == 0) chk("rx_e_unexpected_word", 1, 0);
      else begin
        me_e = sb_q.pop_front();
        chk("rx_e_data", int'(rx_data_e), int'(me_e.data));
        chk("rx_e_parity_err", int'(perr_e), int'(me_e.perr));
        chk("rx_e_frame_err", int'(ferr_e), int'(me_e.ferr));
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    sb_q.push_back(e);
  endtask

  task automatic drive_rx(input logic sel, input logic [7:0] d, input logic bad_par, input logic stop_low);
    logic [10:0] bits;
    int          n;
    build(d, sel, bad_par, stop_low, bits, n);
    for (int k = 0; k < n; k++) begin
      if (sel) rxd_drv_e = bits[k];
      else     rxd_drv_n = bits[k];
      repeat (BP) @(posedge clk);
      #1;
    end
    rxd_drv_n = 1'b1;
    rxd_drv_e = 1'b1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb();
    int g = 0;
    while (sb_q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic check_tx(input logic sel, input logic [7:0] d);
    logic [10:0] bits;
    int          n, errs, g;
    logic        par_seen;
    build(d, sel, 1'b0, 1'b0, bits, n);
    tx_sel = sel;
    tx_dat = d;
    tx_vld = 1'b1;
    g = 0;
    @(negedge clk);
    while (!mon_rdy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    tx_vld   = 1'b0;
    errs     = 0;
    par_seen = 1'b0;
    for (int k = 0; k < n * BP; k++) begin
      @(negedge clk);
      if (mon_txd !== bits[k / BP] || mon_rdy !== 1'b0) errs++;
      if (k == 9 * BP + BP / 2) par_seen = mon_txd;
    end
    chk("tx_frame_bits_and_busy", errs, 0);
    @(negedge clk);
    chk("tx_ready_after_frame", int'(mon_rdy), 1);
    chk("tx_line_idle_after_frame", int'(mon_txd), 1);
    if (sel) chk("tx_even_parity_bit", int'(par_seen), int'(^d));
    @(posedge clk);
    #1;
  endtask

  task automatic tx_word(input logic [7:0] d);
    int g = 0;
    tx_dat = d;
    tx_vld = 1'b1;
    @(negedge clk);
    while (!mon_rdy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk("tx_accept_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen0;
    vecs[0] = '{sel: 1'b1, data: 8'h07, bad_par: 1'b1, stop_low: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{sel: 1'b1, data: 8'h07, bad_par: 1'b0, stop_low: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{sel: 1'b1, data: 8'hC3, bad_par: 1'b0, stop_low: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{sel: 1'b0, data: 8'h3C, bad_par: 1'b0, stop_low: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[4] = '{sel: 1'b0, data: 8'h3C, bad_par: 1'b0, stop_low: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{sel: 1'b1, data: 8'h01, bad_par: 1'b1, stop_low: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b1};

    reset = 1'b1; loop_en = 1'b0; rxd_drv_n = 1'b1; rxd_drv_e = 1'b1;
    tx_sel = 1'b0; tx_vld = 1'b0; tx_dat = 8'h00; rx_ready_n = 1'b1; rx_ready_e = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_txd", int'(txd_n), 1);
    chk("reset_tx_ready", int'(tx_ready_n), 1);
    chk("reset_rx_valid", int'(rx_valid_n), 0);
    chk("reset_rx_data", int'(rx_data_n), 0);
    chk("reset_flags", int'({ferr_n, perr_n, ovr_n}), 0);
    chk("reset_e_txd_ready", int'({txd_e, tx_ready_e, ovr_e}), 6);
    @(posedge clk);
    #1;

    check_tx(1'b0, 8'hA5);

    loop_en = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    push(8'h5A, 1'b0, 1'b0);
    tx_sel = 1'b0;
    tx_word(8'h00);
    tx_word(8'hFF);
    tx_word(8'h5A);
    tx_vld = 1'b0;
    wait_sb();
    chk("loopback_no_overrun", int'(ovr_n), 0);
    repeat (BP * 2) @(posedge clk);
    #1 loop_en = 1'b0;

    check_tx(1'b1, 8'h07);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
      drive_rx(vecs[i].sel, vecs[i].data, vecs[i].bad_par, vecs[i].stop_low);
      wait_sb();
    end

    seen0 = rx_seen_n;
    rxd_drv_n = 1'b0;
    repeat (20) @(posedge clk);
    #1 rxd_drv_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    chk("glitch_no_word", rx_seen_n - seen0, 0);
    push(8'h96, 1'b0, 1'b0);
    drive_rx(1'b0, 8'h96, 1'b0, 1'b0);
    wait_sb();

    rx_ready_n = 1'b0;
    drive_rx(1'b0, 8'h11, 1'b0, 1'b0);
    drive_rx(1'b0, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("overrun_rx_valid", int'(rx_valid_n), 1);
    chk("overrun_rx_data", int'(rx_data_n), 8'h22);
    chk("overrun_flag", int'(ovr_n), 1);
    push(8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1 rx_ready_n = 1'b1;
    @(posedge clk);
    #1 rx_ready_n = 1'b0;
    @(negedge clk);
    chk("consume_rx_valid_low", int'(rx_valid_n), 0);
    chk("overrun_sticky", int'(ovr_n), 1);
    chk("consume_scoreboard", sb_q.size(), 0);
    @(posedge clk);
    #1 rx_ready_n = 1'b1;

    tx_sel = 1'b0; tx_dat = 8'h55; tx_vld = 1'b1;
    @(posedge clk);
    #1 tx_vld = 1'b0;
    rxd_drv_n = 1'b0;
    repeat (3 * BP + 10) @(posedge clk);
    #1 reset = 1'b1; rxd_drv_n = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_txd", int'(txd_n), 1);
    chk("midreset_tx_ready", int'(tx_ready_n), 1);
    chk("midreset_rx_valid", int'(rx_valid_n), 0);
    chk("midreset_rx_data", int'(rx_data_n), 0);
    chk("midreset_flags", int'({ferr_n, perr_n, ovr_n}), 0);
    @(posedge clk);
    #1 loop_en = 1'b1;
    push(8'h81, 1'b0, 1'b0);
    check_tx(1'b0, 8'h81);
    wait_sb();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
